// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divider
module uart_tx_periph #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd1085
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        REN,
    input  logic        WEN,
    input  logic [11:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        txd,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [15:0]   bauddiv, div_q, baud_cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          overflow;
    logic          wr, rd, full, empty, push, pop, bit_end, busy;
    logic          unused_bits;

    assign wr          = CS & WEN;
    assign rd          = CS & REN;
    assign full        = count == (AW+1)'(FIFO_DEPTH);
    assign empty       = count == '0;
    assign busy        = state != IDLE;
    assign bit_end     = baud_cnt == div_q - 16'd1;
    assign push        = wr && Addr[3:2] == 2'd0 && (!full || pop);
    assign unused_bits = ^{Addr[11:4], Addr[1:0], DataIn[31:16]};

    assign DataOut = !rd                ? 32'h0 :
                     Addr[3:2] == 2'd1  ? {27'b0, overflow, empty, full, busy, 1'b0} :
                     Addr[3:2] == 2'd2  ? {16'b0, bauddiv} : 32'h0;

    // shifter state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // next state and FIFO pop; a stop bit rolls straight into the next start when data is waiting
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE:  if (!empty) begin
                pop     = 1'b1;
                state_n = START;
            end
            START: if (bit_end) state_n = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) state_n = STOP;
            STOP:  if (bit_end) begin
                pop     = !empty;
                state_n = empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk)
        if (push) mem[wptr] <= DataIn[7:0];

    // FIFO pointers, registers, baud timing and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bauddiv  <= DIV_RESET;
            div_q    <= 16'd1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            irq      <= 1'b1;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr     <= rptr + 1'b1;
                shift    <= mem[rptr];
                div_q    <= bauddiv == 16'd0 ? 16'd1 : bauddiv;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else if (busy) begin
                baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
                if (state == DATA && bit_end) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= (wr && Addr[3:2] == 2'd0 && full && !pop) ||
                        (overflow && !(wr && Addr[3:2] == 2'd1 && DataIn[4]));
            if (wr && Addr[3:2] == 2'd2) bauddiv <= DataIn[15:0];
            txd      <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
            irq      <= state == IDLE && empty;
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed self-checking bench for uart_tx_periph
module tb_uart_tx_periph;
    logic        clk = 1'b0, rst = 1'b1, CS = 1'b0, REN = 1'b0, WEN = 1'b0;
    logic [11:0] Addr = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic        txd, irq;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    uart_tx_periph dut (
        .clk(clk), .rst(rst), .CS(CS), .REN(REN), .WEN(WEN),
        .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .txd(txd), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        CS = 1'b1; WEN = 1'b1; Addr = a; DataIn = d;
        @(posedge clk); #1;
        CS = 1'b0; WEN = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        CS = 1'b1; REN = 1'b1; Addr = a;
        #1 check(tag, DataOut, exp);
        CS = 1'b0; REN = 1'b0;
    endtask

    // checks txd on each falling edge against start, 8 data bits LSB first, stop
    task automatic frame(input logic [7:0] b, input int div, input int skip);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = skip; k < 10 * div; k++) begin
            @(negedge clk);
            check($sformatf("txd b%02h k%0d", b, k), {31'b0, txd}, {31'b0, f[k / div]});
        end
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(tag, {31'b0, txd}, 32'h1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst txd", {31'b0, txd}, 32'h1);
        check("rst irq", {31'b0, irq}, 32'h1);
        rd_chk("rst status", 12'h4, 32'h8);
        rd_chk("rst baud", 12'h8, 32'd1085);
        rd_chk("txdata rd", 12'h0, 32'h0);
        rd_chk("reserved rd", 12'hC, 32'h0);
        Addr = 12'h8; REN = 1'b1;
        #1 check("no cs rd", DataOut, 32'h0);
        REN = 1'b0;

        // single frame, div 4, upper BAUDDIV bits ignored
        wr(12'h8, 32'hFFFF_0004);
        rd_chk("baud4", 12'h8, 32'h4);
        wr(12'h0, 32'h55);
        @(negedge clk); @(negedge clk);
        check("irq busy", {31'b0, irq}, 32'h0);
        rd_chk("status busy", 12'h4, 32'hA);
        frame(8'h55, 4, 0);
        @(negedge clk);
        check("irq done", {31'b0, irq}, 32'h1);
        rd_chk("status done", 12'h4, 32'h8);

        // back-to-back frames, div 2
        wr(12'h8, 32'd2);
        wr(12'h0, 32'hA1);
        wr(12'h0, 32'h3C);
        wr(12'h0, 32'hFF);
        frame(8'hA1, 2, 0);
        frame(8'h3C, 2, 0);
        frame(8'hFF, 2, 0);
        idle_chk("b2b idle", 1);

        // fill FIFO, overflow, clear
        wr(12'h8, 32'd100);
        for (int i = 0; i < 9; i++) wr(12'h0, 32'(i));
        rd_chk("status full", 12'h4, 32'h6);
        wr(12'h0, 32'h09);
        rd_chk("status ovf", 12'h4, 32'h16);
        wr(12'h4, 32'h10);
        rd_chk("status clr", 12'h4, 32'h6);
        frame(8'h00, 100, 8);
        for (int i = 1; i < 9; i++) frame(8'(i), 100, 0);
        idle_chk("dropped byte", 200);
        rd_chk("status drain", 12'h4, 32'h8);

        // div 0 acts as 1; mid-frame divider change only applies next frame
        wr(12'h8, 32'd0);
        wr(12'h0, 32'hF0);
        wr(12'h8, 32'd8);
        @(negedge clk);
        frame(8'hF0, 1, 0);
        rd_chk("baud8", 12'h8, 32'h8);
        wr(12'h0, 32'h0F);
        @(negedge clk); @(negedge clk);
        frame(8'h0F, 8, 0);

        // reset in the middle of the data bits
        wr(12'h8, 32'd10);
        wr(12'h0, 32'h00);
        repeat (27) @(negedge clk);
        check("mid data txd", {31'b0, txd}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst mid txd", {31'b0, txd}, 32'h1);
        check("rst mid irq", {31'b0, irq}, 32'h1);
        rd_chk("rst mid status", 12'h4, 32'h8);
        rd_chk("rst mid baud", 12'h8, 32'd1085);
        idle_chk("post rst idle", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
